// File: rtl/ram64x18_fifo_pkg.sv
// Shared widths, word types and access-kind encoding for the ram64x18 byte FIFO.
package fifo_pkg;

   localparam int unsigned FIFO_DEPTH = 128;
   localparam int unsigned FIFO_BITS  = 7;
   localparam int unsigned FIFO_WIDTH = 8;

   typedef logic [FIFO_BITS-1:0]  ptr_t;
   typedef logic [FIFO_WIDTH-1:0] data_t;

   typedef enum logic [1:0] {
      ACC_NONE = 2'b00,
      ACC_WR   = 2'b01,
      ACC_RD   = 2'b10,
      ACC_BOTH = 2'b11
   } acc_e;

   function automatic acc_e acc_kind(input logic wr, input logic rd);
      return acc_e'({rd, wr});
   endfunction

endpackage

// File: rtl/ram64x18_fifo_if.sv
// APB-side byte FIFO bus: write/read strobes, threshold level, data and status flags.
interface ram64x18_fifo_if;

   fifo_pkg::data_t data_in;
   logic            write_n;
   logic            read_n;
   fifo_pkg::ptr_t  LEVEL;
   fifo_pkg::data_t data_out;
   logic            full;
   logic            empty;
   logic            half;

   modport master (
      output data_in, write_n, read_n, LEVEL,
      input  data_out, full, empty, half
   );

   modport slave (
      input  data_in, write_n, read_n, LEVEL,
      output data_out, full, empty, half
   );

endinterface

// File: rtl/ram64x18_fifo_ram128x8.sv
// 128x8 storage wrapper: active-low write enable, registered read address, transparent output.
module fifo_ram128x8
   import fifo_pkg::*;
(
   input  logic  clock,
   input  data_t Data,
   input  ptr_t  WAddress,
   input  logic  WE,
   input  ptr_t  RAddress,
   output data_t Q
);

   data_t r_mem [FIFO_DEPTH];
   ptr_t  r_raddr;

   always_ff @(posedge clock) begin
      if (!WE) begin
         r_mem[WAddress] <= Data;
      end
      r_raddr <= RAddress;
   end

   assign Q = r_mem[r_raddr];

endmodule

// File: rtl/ram64x18_fifo.sv
// Single-clock byte FIFO on one 128x8 block RAM; full/empty/threshold flags from the counter.
// Optional FIFO_ASSERT_EN adds simulation checks for write-while-full and read-while-empty.
module ram64x18_fifo
   import fifo_pkg::*;
(
   input  logic              clock,
   input  logic              reset_n,
   ram64x18_fifo_if.slave    bus
);

   ptr_t  r_wr_ptr;
   ptr_t  r_rd_ptr;
   ptr_t  r_count;
   data_t r_data_out;
   logic  r_read_hold;
   logic  r_rd_acc;

   logic  w_full;
   logic  w_empty;
   logic  w_rd_acc;
   logic  w_wr_acc;
   logic  w_we_n;
   data_t w_ram_q;
   acc_e  w_acc;

   assign w_full   = (r_count == ptr_t'(FIFO_DEPTH - 1));
   assign w_empty  = (r_count == '0);
   assign w_rd_acc = !bus.read_n && !w_empty;
   // A write while full still lands when a read frees a slot in the same cycle.
   assign w_wr_acc = !bus.write_n && (!w_full || w_rd_acc);
   assign w_we_n   = ~w_wr_acc;
   assign w_acc    = acc_kind(w_wr_acc, w_rd_acc);

   fifo_ram128x8 u_ram (
      .clock    (clock),
      .Data     (bus.data_in),
      .WAddress (r_wr_ptr),
      .WE       (w_we_n),
      .RAddress (r_rd_ptr),
      .Q        (w_ram_q)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_data_out  <= '0;
         r_read_hold <= 1'b1;
         r_rd_acc    <= 1'b0;
      end else begin
         if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
         case (w_acc)
            ACC_WR:  r_count <= r_count + 1'b1;
            ACC_RD:  r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         r_read_hold <= bus.read_n;
         r_rd_acc    <= w_rd_acc;
         if (!r_read_hold && r_rd_acc) begin
            r_data_out <= w_ram_q;
         end
      end
   end

   assign bus.data_out = r_data_out;
   assign bus.full     = w_full;
   assign bus.empty    = w_empty;
   assign bus.half     = (r_count >= bus.LEVEL);

`ifdef FIFO_ASSERT_EN
   a_no_wr_full : assert property (@(posedge clock) disable iff (!reset_n)
      !(!bus.write_n && w_full && !w_rd_acc))
      else $error("write while full");
   a_no_rd_empty : assert property (@(posedge clock) disable iff (!reset_n)
      !(!bus.read_n && w_empty))
      else $error("read while empty");
`endif

endmodule

// File: tb/tb_ram64x18_fifo.sv
// Bench for ram64x18_fifo: fixed vector table, directed corner sequences, random traffic vs queue model.
module tb_ram64x18_fifo;
   import fifo_pkg::*;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;

   ram64x18_fifo_if bus();

   ram64x18_fifo dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   // Reference model: byte queue plus the byte that becomes visible one edge after its read.
   logic [7:0] q[$];
   logic [7:0] m_dout      = 8'h00;
   logic       m_pend      = 1'b0;
   logic [7:0] m_pend_byte = 8'h00;

   typedef struct {
      logic       rst_n;
      logic       wr_n;
      logic       rd_n;
      logic [7:0] din;
      logic [6:0] level;
      logic [7:0] e_dout;
      logic       e_empty;
      logic       e_full;
      logic       e_half;
   } vec_t;

   vec_t vt[$];

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_edge(input logic rst_n, input logic wr_n, input logic rd_n, input logic [7:0] din);
      logic rd_ok, wr_ok;
      if (!rst_n) begin
         q.delete();
         m_dout = 8'h00;
         m_pend = 1'b0;
      end else begin
         rd_ok = !rd_n && (q.size() > 0);
         wr_ok = !wr_n && ((q.size() < 127) || rd_ok);
         if (m_pend) m_dout = m_pend_byte;
         m_pend = rd_ok;
         if (rd_ok) m_pend_byte = q.pop_front();
         if (wr_ok) q.push_back(din);
      end
   endtask

   task automatic drive(input logic rst_n, input logic wr_n, input logic rd_n, input logic [7:0] din);
      reset_n     = rst_n;
      bus.write_n = wr_n;
      bus.read_n  = rd_n;
      bus.data_in = din;
      @(posedge clock);
      model_edge(rst_n, wr_n, rd_n, din);
      @(negedge clock);
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_dout"},  bus.data_out, m_dout);
      chk({tag, "_empty"}, bus.empty, (q.size() == 0) ? 1 : 0);
      chk({tag, "_full"},  bus.full,  (q.size() == 127) ? 1 : 0);
      chk({tag, "_half"},  bus.half,  (q.size() >= int'(bus.LEVEL)) ? 1 : 0);
   endtask

   task automatic cyc(input string tag, input logic rst_n, input logic wr_n, input logic rd_n, input logic [7:0] din);
      drive(rst_n, wr_n, rd_n, din);
      check_model(tag);
   endtask

   initial begin
      bus.write_n = 1'b1;
      bus.read_n  = 1'b1;
      bus.data_in = 8'h00;
      bus.LEVEL   = 7'd64;

      //           rst   wr    rd    din    lvl    dout   emp   full  half
      vt.push_back('{1'b0, 1'b1, 1'b1, 8'h00, 7'd64, 8'h00, 1'b1, 1'b0, 1'b0});
      vt.push_back('{1'b1, 1'b1, 1'b1, 8'h00, 7'd64, 8'h00, 1'b1, 1'b0, 1'b0});
      vt.push_back('{1'b1, 1'b0, 1'b1, 8'h11, 7'd64, 8'h00, 1'b0, 1'b0, 1'b0});
      vt.push_back('{1'b1, 1'b0, 1'b1, 8'h22, 7'd64, 8'h00, 1'b0, 1'b0, 1'b0});
      vt.push_back('{1'b1, 1'b0, 1'b1, 8'h33, 7'd64, 8'h00, 1'b0, 1'b0, 1'b0});
      vt.push_back('{1'b1, 1'b1, 1'b0, 8'h00, 7'd64, 8'h00, 1'b0, 1'b0, 1'b0});
      vt.push_back('{1'b1, 1'b1, 1'b0, 8'h00, 7'd64, 8'h11, 1'b0, 1'b0, 1'b0});
      vt.push_back('{1'b1, 1'b1, 1'b0, 8'h00, 7'd64, 8'h22, 1'b1, 1'b0, 1'b0});
      vt.push_back('{1'b1, 1'b1, 1'b1, 8'h00, 7'd64, 8'h33, 1'b1, 1'b0, 1'b0});
      vt.push_back('{1'b1, 1'b1, 1'b0, 8'h00, 7'd64, 8'h33, 1'b1, 1'b0, 1'b0});
      vt.push_back('{1'b1, 1'b1, 1'b1, 8'h00, 7'd64, 8'h33, 1'b1, 1'b0, 1'b0});
      vt.push_back('{1'b1, 1'b0, 1'b1, 8'hA1, 7'd3,  8'h33, 1'b0, 1'b0, 1'b0});
      vt.push_back('{1'b1, 1'b0, 1'b1, 8'hA2, 7'd3,  8'h33, 1'b0, 1'b0, 1'b0});
      vt.push_back('{1'b1, 1'b0, 1'b1, 8'hA3, 7'd3,  8'h33, 1'b0, 1'b0, 1'b1});
      vt.push_back('{1'b1, 1'b1, 1'b0, 8'h00, 7'd3,  8'h33, 1'b0, 1'b0, 1'b0});
      vt.push_back('{1'b1, 1'b1, 1'b1, 8'h00, 7'd3,  8'hA1, 1'b0, 1'b0, 1'b0});
      vt.push_back('{1'b1, 1'b1, 1'b1, 8'h00, 7'd0,  8'hA1, 1'b0, 1'b0, 1'b1});
      vt.push_back('{1'b0, 1'b1, 1'b1, 8'h00, 7'd0,  8'h00, 1'b1, 1'b0, 1'b1});
      vt.push_back('{1'b0, 1'b1, 1'b1, 8'h00, 7'd64, 8'h00, 1'b1, 1'b0, 1'b0});

      foreach (vt[i]) begin
         bus.LEVEL = vt[i].level;
         drive(vt[i].rst_n, vt[i].wr_n, vt[i].rd_n, vt[i].din);
         chk($sformatf("vec%0d_dout", i),  bus.data_out, vt[i].e_dout);
         chk($sformatf("vec%0d_empty", i), bus.empty,    vt[i].e_empty);
         chk($sformatf("vec%0d_full", i),  bus.full,     vt[i].e_full);
         chk($sformatf("vec%0d_half", i),  bus.half,     vt[i].e_half);
      end

      // Fill to capacity, one ignored write, drain in order.
      bus.LEVEL = 7'd64;
      cyc("fill_idle", 1'b1, 1'b1, 1'b1, 8'h00);
      for (int i = 0; i < 127; i++) cyc("fill", 1'b1, 1'b0, 1'b1, 8'(i));
      chk("fill_full", bus.full, 1);
      cyc("over_wr", 1'b1, 1'b0, 1'b1, 8'hFF);
      chk("over_wr_full", bus.full, 1);
      for (int k = 0; k < 128; k++) begin
         cyc("drain", 1'b1, 1'b1, 1'b0, 8'h00);
         if (k >= 1) chk("drain_order", bus.data_out, k - 1);
      end
      cyc("drain_end", 1'b1, 1'b1, 1'b1, 8'h00);
      chk("drain_last", bus.data_out, 8'h7E);
      chk("drain_empty", bus.empty, 1);

      // Count held at 5 through 200 simultaneous read/write cycles across pointer wrap.
      bus.LEVEL = 7'd5;
      for (int i = 0; i < 5; i++) cyc("rw_pre", 1'b1, 1'b0, 1'b1, 8'(8'hC0 + i));
      for (int i = 0; i < 200; i++) cyc("rw", 1'b1, 1'b0, 1'b0, 8'(i));
      chk("rw_half5", bus.half, 1);
      bus.LEVEL = 7'd6;
      #1;
      chk("rw_half6", bus.half, 0);
      chk("rw_empty", bus.empty, 0);
      for (int i = 0; i < 7; i++) cyc("rw_drain", 1'b1, 1'b1, 1'b0, 8'h00);
      chk("rw_drain_last", bus.data_out, 8'd199);

      // Reset mid-operation with a read in flight.
      bus.LEVEL = 7'd64;
      for (int i = 0; i < 10; i++) cyc("rst_fill", 1'b1, 1'b0, 1'b1, 8'(8'h40 + i));
      cyc("rst_rd", 1'b1, 1'b1, 1'b0, 8'h00);
      cyc("rst", 1'b0, 1'b1, 1'b1, 8'h00);
      chk("rst_dout", bus.data_out, 8'h00);
      chk("rst_empty", bus.empty, 1);
      cyc("rst_rd_empty", 1'b1, 1'b1, 1'b0, 8'h00);
      cyc("rst_idle", 1'b1, 1'b1, 1'b1, 8'h00);
      chk("rst_rd_empty_hold", bus.data_out, 8'h00);
      cyc("rst_wr", 1'b1, 1'b0, 1'b1, 8'h5A);
      cyc("rst_rd2", 1'b1, 1'b1, 1'b0, 8'h00);
      cyc("rst_idle2", 1'b1, 1'b1, 1'b1, 8'h00);
      chk("rst_ptr_zero_data", bus.data_out, 8'h5A);

      // Random traffic with phases biased toward filling and draining.
      for (int i = 0; i < 4000; i++) begin
         int unsigned phase, wp, rp;
         logic rst_n, wr_n, rd_n;
         phase = (i / 250) % 4;
         wp = (phase == 0) ? 90 : (phase == 2) ? 15 : 50;
         rp = (phase == 0) ? 15 : (phase == 2) ? 90 : 50;
         if ($urandom_range(99) < 3) bus.LEVEL = 7'($urandom_range(127));
         rst_n = ($urandom_range(699) != 0);
         wr_n  = !($urandom_range(99) < wp);
         rd_n  = !($urandom_range(99) < rp);
         cyc("rand", rst_n, wr_n, rd_n, 8'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
